// File: rtl/inv_key_schedule_pkg.sv
// Shared AES-128 definitions for the inverse key schedule: key/round types, RCON table
// and a forward S-box function built from GF(2^8) inversion plus the affine transform.
package inv_key_schedule_pkg;

  localparam int unsigned NUM_ROUNDS_128 = 10;

  typedef logic [3:0]   round_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] key_t;

  // Indexed directly by round number; entries beyond 10 are unused padding.
  localparam logic [15:0][7:0] RCON = {
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
  };

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0), then the affine step.
  function automatic logic [7:0] sbox_fn(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    logic [7:0] b;
    inv = 8'h01;
    sq  = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i != 0) inv = gf_mul(inv, sq);
      sq = gf_mul(sq, sq);
    end
    b = inv;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/inv_key_schedule_step.sv
// Forward AES S-box and the combinational reverse key-expansion step prev(key, round).
module aes_sbox
  import inv_key_schedule_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = sbox_fn(in_byte);

endmodule

module inv_key_step
  import inv_key_schedule_pkg::*;
(
  input  key_t   key,
  input  round_t round,
  output key_t   prev_key
);

  word_t k0, k1, k2, k3;
  word_t p0, p1, p2, p3;
  word_t rot_word;
  word_t sub_word;

  assign {k0, k1, k2, k3} = key;

  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;

  assign rot_word = {p3[23:0], p3[31:24]};

  genvar g;
  for (g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_word[8*g +: 8]),
      .out_byte (sub_word[8*g +: 8])
    );
  end

  assign p0 = k0 ^ sub_word ^ {RCON[round], 24'h0};

  assign prev_key = {p0, p1, p2, p3};

endmodule

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 reverse key expansion: accepts the round-10 key, streams rounds 10..0.
// Optional build macro INV_KEY_ZEROIZE_EN clears the held key on the final handshake.
module inv_key_schedule
  import inv_key_schedule_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_key,
  output logic [3:0]   out_round,
  output logic         out_last
);

  if (NUM_ROUNDS != NUM_ROUNDS_128) begin : g_bad_rounds
    $error("inv_key_schedule: only NUM_ROUNDS=10 (AES-128) is supported");
  end

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t state;
  key_t   key_q;
  round_t round_q;
  key_t   prev_key;

  inv_key_step u_step (
    .key      (key_q),
    .round    (round_q),
    .prev_key (prev_key)
  );

  assign out_key   = key_q;
  assign out_round = round_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      key_q     <= '0;
      round_q   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            key_q     <= in_key;
            round_q   <= round_t'(NUM_ROUNDS);
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (round_q != '0) begin
              key_q    <= prev_key;
              round_q  <= round_q - 4'd1;
              out_last <= (round_q == 4'd1);
            end else begin
`ifdef INV_KEY_ZEROIZE_EN
              key_q <= '0;
`endif
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Self-checking bench for inv_key_schedule against a word-array reverse key expansion model.
module tb_inv_key_schedule;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_key;
  logic [3:0]   out_round;
  logic         out_last;

  int unsigned n_cmp;
  int unsigned n_err;

  logic [7:0]   sbox_tab [0:255];
  logic [127:0] ref_keys [0:10];
  logic [127:0] got_keys [0:10];

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  inv_key_schedule #(.NUM_ROUNDS(10)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_key   (out_key),
    .out_round (out_round),
    .out_last  (out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // S-box table from the generator-3 walk over GF(2^8).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tab[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox_tab[r[31:24]], sbox_tab[r[23:16]], sbox_tab[r[15:8]], sbox_tab[r[7:0]]};
  endfunction

  // Undo w[i+4] = w[i] ^ temp(w[i+3]) walking the 44-word schedule backwards.
  task automatic expand_reverse(input logic [127:0] k10);
    logic [31:0] w [0:43];
    logic [7:0]  rcon [1:10];
    rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    {w[40], w[41], w[42], w[43]} = k10;
    for (int i = 39; i >= 0; i--) begin
      if (i % 4 == 0)
        w[i] = w[i+4] ^ sub_rot(w[i+3]) ^ {rcon[(i+4)/4], 24'h0};
      else
        w[i] = w[i+4] ^ w[i+3];
    end
    for (int r = 0; r <= 10; r++) ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic run_seq(input logic [127:0] key, input int bp_round, input bit rnd,
                         input bit hold, input logic [127:0] hold_key);
    int  r;
    int  cycles;
    int  stall_left;
    bit  stalled;
    bit  done;
    bit  rdy;
    expand_reverse(key);
    cycles = 0;
    while (!in_ready && cycles < 20) begin
      @(posedge clock); #1;
      cycles++;
    end
    check("accept_ready", {127'h0, in_ready}, 128'h1);
    in_valid = 1'b1;
    in_key   = key;
    @(posedge clock); #1;
    if (hold) in_key = hold_key;
    else in_valid = 1'b0;
    r = 10; cycles = 0; stall_left = 0; stalled = 0; done = 0;
    while (!done && cycles < 200) begin
      check("out_valid", {127'h0, out_valid}, 128'h1);
      check("in_ready_emit", {127'h0, in_ready}, 128'h0);
      check("out_round", {124'h0, out_round}, 128'(r));
      check($sformatf("out_key_r%0d", r), out_key, ref_keys[r]);
      check("out_last", {127'h0, out_last}, {127'h0, r == 0});
      got_keys[r] = out_key;
      if (stall_left > 0) begin
        rdy = 1'b0; stall_left--;
      end else if (r == bp_round && !stalled) begin
        rdy = 1'b0; stalled = 1; stall_left = 2;
      end else if (rnd) rdy = 1'($urandom_range(0, 1));
      else rdy = 1'b1;
      out_ready = rdy;
      @(posedge clock); #1;
      cycles++;
      if (rdy) begin
        if (r == 0) done = 1;
        else r--;
      end
    end
    check("seq_timeout", {127'h0, done}, 128'h1);
    check("idle_valid", {127'h0, out_valid}, 128'h0);
    check("idle_ready", {127'h0, in_ready}, 128'h1);
    check("idle_last", {127'h0, out_last}, 128'h0);
`ifdef INV_KEY_ZEROIZE_EN
    check("idle_key", out_key, 128'h0);
`else
    check("idle_key", out_key, ref_keys[0]);
`endif
  endtask

  initial begin
    logic [127:0] k;
    int n;
    n_cmp = 0; n_err = 0;
    build_sbox();
    reset = 1'b1; in_valid = 1'b0; in_key = '0; out_ready = 1'b0;
    #2;
    check("rst_in_ready", {127'h0, in_ready}, 128'h0);
    check("rst_out_valid", {127'h0, out_valid}, 128'h0);
    check("rst_out_key", out_key, 128'h0);
    check("rst_out_round", {124'h0, out_round}, 128'h0);
    check("rst_out_last", {127'h0, out_last}, 128'h0);
    repeat (3) @(posedge clock);
    #1;
    check("rst_hold_ready", {127'h0, in_ready}, 128'h0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("post_rst_ready", {127'h0, in_ready}, 128'h1);
    check("post_rst_valid", {127'h0, out_valid}, 128'h0);

    run_seq(FIPS_K10, -1, 0, 0, '0);
    check("fips_k10", got_keys[10], FIPS_K10);
    check("fips_k9", got_keys[9], FIPS_K9);
    check("fips_k0", got_keys[0], FIPS_K0);

    run_seq(FIPS_K10, 7, 0, 0, '0);
    check("bp_fips_k0", got_keys[0], FIPS_K0);

    k = {$urandom, $urandom, $urandom, $urandom};
    run_seq(FIPS_K10, -1, 0, 1, k);
    check("hold_fips_k0", got_keys[0], FIPS_K0);
    run_seq(k, -1, 0, 0, '0);

    // Asynchronous reset landing between clock edges at round 5.
    in_valid = 1'b1; in_key = FIPS_K10; out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_round != 4'd5 && n < 30) begin
      @(posedge clock); #1;
      n++;
    end
    check("mid_round5", {124'h0, out_round}, 128'h5);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_valid", {127'h0, out_valid}, 128'h0);
    check("mid_rst_key", out_key, 128'h0);
    check("mid_rst_round", {124'h0, out_round}, 128'h0);
    check("mid_rst_ready", {127'h0, in_ready}, 128'h0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    run_seq(FIPS_K10, -1, 0, 0, '0);

    run_seq(128'h0, -1, 0, 0, '0);
    run_seq(128'h0, -1, 0, 0, '0);

    for (int i = 0; i < 6; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      run_seq(k, int'($urandom_range(0, 10)), 1, 0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
